c6502_bus_arbiter: RTL and testbench
====================================

# c6502_bus_arbiter

- Shares one synchronous single-port 64 KiB memory between three requesters:
  - the c6502 core;
  - a video fetch port;
  - a DMA port.
- Paces the core through its `ce` input, so the core advances one state per granted bus slot.
- Sits between `c6502` and the memory/video subsystems; the core connects as `address`/`out`/`we`/`in`/`ce`.
- Video has priority, bounded to at most every other slot while anyone else is waiting; DMA and CPU alternate round-robin.

## Interface
- `ADDR_W`, 16: address width of all ports.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cpu_address`  in  ADDR_W  core bus address.
- `cpu_out`  in  8  core write data.
- `cpu_we`  in  1  core write request (held until the next `cpu_ce` edge).
- `cpu_halt`  in  1  1 = CPU requests no slots (core frozen).
- `cpu_ce`  out  1  clock enable to core.
- `cpu_in`  out  8  read data to core.
- `vid_req`  in  1  video read request; hold address until ack.
- `vid_address`  in  ADDR_W  video address.
- `vid_ack`  out  1  one-cycle pulse: `vid_data` valid.
- `vid_data`  out  8  video read data.
- `dma_req`  in  1  DMA request; hold address/we/wdata until ack.
- `dma_address`  in  ADDR_W  DMA address.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_wdata`  in  8  DMA write data.
- `dma_ack`  out  1  one-cycle pulse: access done; `dma_rdata` valid on reads.
- `dma_rdata`  out  8  DMA read data.
- `mem_address`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write strobe.
- `mem_out`  out  8  memory write data.
- `mem_in`  in  8  memory read data, valid the cycle after address is presented.

## Operation

**Slot structure**
- Fixed 2-cycle slot tracked by a `phase` register: ADDR (0) then DATA (1), alternating every clock.

**ADDR cycle**
- Owner is chosen combinationally from requests sampled this cycle.
- `mem_address`, `mem_we` and `mem_out` are driven combinationally from the chosen owner.
- Owner is registered at the clock edge.
- Writes happen only in ADDR.

**DATA cycle**
- `mem_address` holds the registered owner's address; `mem_we` = 0.
- Owner completion:
  - CPU → `cpu_ce` = 1.
  - VID → `vid_ack` = 1.
  - DMA → `dma_ack` = 1.
  - NONE → no pulse.
- `cpu_in`, `vid_data` and `dma_rdata` are all driven by `mem_in`.

**Pending set**
- V = `vid_req`; D = `dma_req`; C = !`cpu_halt`.

**Grant rule (ADDR cycle)**
- VID if V and (last owner ≠ VID or !(D|C)).
- Otherwise, between D and C:
  - both pending → `rr` pointer wins, and `rr` flips to the loser;
  - exactly one pending → it wins, `rr` unchanged.
- Otherwise NONE.
- `last_owner` updates every slot, including NONE.

**CPU writes**
- `cpu_we` seen in an ADDR cycle where CPU owns the slot → `mem_we` = 1, `mem_out` = `cpu_out`.
- The core drops `we` after the `ce` edge, so each write is issued exactly once.

**Same-slot conflict**
- Any requester may keep `req` high after its ack to request the next slot; it is re-arbitrated like a fresh request.
- Write and read in the same slot is impossible by construction (single owner).

## Timing
- Reset (`reset_n` low, asynchronous):
  - `phase` = ADDR, owner = NONE, `last_owner` = NONE, `rr` = CPU.
  - `cpu_ce`, `vid_ack`, `dma_ack` and `mem_we` forced to 0 while reset is held.
- First grant is in the first ADDR cycle after release.
- Latency from grant to completion:
  - CPU and DMA: request seen in ADDR, ack/`ce` in the following DATA cycle (1 clock).
  - Video: worst case 1 extra slot, i.e. 3 clocks from `req` rise to ack.
- `cpu_ce` duty is at most 1/2 (every DATA cycle), the DATA cycle of CPU-owned slots only.
- With DMA and CPU both active and no video: alternating slots, CPU advances every 4 clocks.
- Mid-slot reset: the slot is abandoned, no ack, no write.
- A DATA-cycle reset loses the completion; requesters must keep `req` high and are re-granted.
- `cpu_halt` rising in a DATA cycle does not cancel a CPU slot already granted.

## Test plan
- Reset release, `cpu_halt` = 0, V = D = 0, memory[0000] = A9:
  - `cpu_ce` pulses on clocks 1, 3, 5, …
  - `mem_address` = 0000 then 0001; `cpu_in` = A9 on the first pulse.
- CPU write: core executes STA $0200 with A = 55 → exactly one `mem_we` pulse with `mem_address` = 0200 and `mem_out` = 55; memory[0200] = 55.
- Video saturation: `vid_req` held high, CPU running → grants alternate VID, CPU, VID, CPU; `vid_ack` every 4 clocks; never two consecutive VID slots.
- DMA vs CPU, no video: `dma_req` held (read of 1234 = 7E) → DMA/CPU alternate; every `dma_ack` carries `dma_rdata` = 7E.
- `cpu_halt` = 1 with only `vid_req` → VID every slot (2 clocks); `cpu_ce` stays 0.
- All requests idle with `cpu_halt` = 1 → NONE slots: no acks, `mem_we` = 0.
- `reset_n` pulsed low during the DATA cycle of a DMA write slot → no `dma_ack`, at most the ADDR write already done; after release `dma_req` is re-granted within 2 slots.

Source files
------------

// File: rtl/c6502_bus_arbiter.sv
// c6502_bus_arbiter: shares a single-port memory between the 6502 core, video and DMA
// using fixed two-cycle slots (ADDR, DATA).
module c6502_bus_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_out,
  input  logic              cpu_we,
  input  logic              cpu_halt,
  output logic              cpu_ce,
  output logic [7:0]        cpu_in,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_address,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic              dma_we,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [7:0]        mem_out,
  input  logic [7:0]        mem_in
);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_DMA} owner_e;
  logic   phase_q, phase_d;
  logic   rr_q, rr_d;
  owner_e owner_q, owner_d, grant, sel;
  logic   cpu_pend;
  // owner_q also serves as the last owner: it only changes at the ADDR edge, once per slot
  always_comb begin
    cpu_pend = !cpu_halt;
    grant    = OWN_NONE;
    rr_d     = rr_q;
    if (vid_req && (owner_q != OWN_VID || !(dma_req || cpu_pend))) grant = OWN_VID;
    else if (dma_req && cpu_pend) begin
      grant = rr_q ? OWN_DMA : OWN_CPU;
      rr_d  = !phase_q ? !rr_q : rr_q;
    end
    else if (dma_req) grant = OWN_DMA;
    else if (cpu_pend) grant = OWN_CPU;
    phase_d     = !phase_q;
    owner_d     = phase_q ? owner_q : grant;
    sel         = phase_q ? owner_q : grant;
    mem_address = sel == OWN_VID ? vid_address : sel == OWN_DMA ? dma_address : cpu_address;
    mem_we      = reset_n && !phase_q && ((sel == OWN_CPU && cpu_we) || (sel == OWN_DMA && dma_we));
    mem_out     = sel == OWN_DMA ? dma_wdata : cpu_out;
    cpu_ce      = reset_n && phase_q && owner_q == OWN_CPU;
    vid_ack     = reset_n && phase_q && owner_q == OWN_VID;
    dma_ack     = reset_n && phase_q && owner_q == OWN_DMA;
    cpu_in      = mem_in;
    vid_data    = mem_in;
    dma_rdata   = mem_in;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      owner_q <= OWN_NONE;
      rr_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end
endmodule

// File: tb/tb_c6502_bus_arbiter.sv
// tb_c6502_bus_arbiter: vector table, reset corner cases and randomized slots
// checked against a slot-level reference model with its own memory image.
module tb_c6502_bus_arbiter;
  localparam int NONE = 0, CPU = 1, VID = 2, DMA = 3;
  logic        clock = 0, reset_n = 0;
  logic [15:0] cpu_address, vid_address, dma_address, mem_address;
  logic [7:0]  cpu_out, cpu_in, vid_data, dma_wdata, dma_rdata, mem_out, mem_in;
  logic        cpu_we, cpu_halt, cpu_ce, vid_req, vid_ack, dma_req, dma_we, dma_ack, mem_we;
  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  int checks = 0, errors = 0;
  int hist[$];
  int contests[$];

  c6502_bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_halt(cpu_halt),
    .cpu_ce(cpu_ce), .cpu_in(cpu_in),
    .vid_req(vid_req), .vid_address(vid_address), .vid_ack(vid_ack), .vid_data(vid_data),
    .dma_req(dma_req), .dma_address(dma_address), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_we(mem_we), .mem_out(mem_out), .mem_in(mem_in)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_address] <= mem_out;
    mem_in <= mem[mem_address];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Grant chosen from the rules: video unless it had the previous slot and others wait;
  // contested DMA/CPU slots alternate, the CPU winning the first contest.
  function automatic int model_grant(input bit v, input bit d, input bit c);
    int last, g;
    last = hist.size() != 0 ? hist[$] : NONE;
    if (v && (last != VID || !(d || c))) g = VID;
    else if (d && c) begin
      g = contests.size() == 0 ? CPU : (contests[$] == CPU ? DMA : CPU);
      contests.push_back(g);
    end
    else g = d ? DMA : c ? CPU : NONE;
    hist.push_back(g);
    return g;
  endfunction

  function automatic logic [15:0] owner_addr(input int own);
    return own == VID ? vid_address : own == DMA ? dma_address : cpu_address;
  endfunction

  task automatic slot(input int own, input bit exp_we, input bit cd, input logic [7:0] dat, input string tag);
    @(negedge clock);
    if (own != NONE) chk({tag, " addr"}, mem_address, owner_addr(own));
    chk({tag, " addr we"}, mem_we, exp_we);
    if (exp_we) chk({tag, " wdata"}, mem_out, own == DMA ? dma_wdata : cpu_out);
    chk({tag, " addr-phase acks"}, {cpu_ce, vid_ack, dma_ack}, 0);
    @(negedge clock);
    chk({tag, " acks"}, {cpu_ce, vid_ack, dma_ack}, {own == CPU, own == VID, own == DMA});
    chk({tag, " data we"}, mem_we, 0);
    if (cd) chk({tag, " rdata"}, own == CPU ? cpu_in : own == VID ? vid_data : dma_rdata, dat);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    cpu_we = 1; cpu_halt = 0; vid_req = 1; dma_req = 1; dma_we = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset mem_we", mem_we, 0);
    chk("reset acks", {cpu_ce, vid_ack, dma_ack}, 0);
    @(posedge clock);
    #1;
    reset_n = 1;
    hist.delete();
    contests.delete();
  endtask

  typedef struct {
    bit v, d, dwe, halt, cwe;
    logic [7:0] wd;
    int own;
    bit we, cd;
    logic [7:0] dat;
  } vec_t;
  vec_t tbl[17];

  initial begin
    bit got, vfree, dfree, cmoved;
    int own;
    logic [15:0] a;
    tbl[0]  = '{1, 1, 0, 0, 0, 8'h00, VID,  0, 1, 8'hC3};
    tbl[1]  = '{1, 1, 0, 0, 0, 8'h00, CPU,  0, 1, 8'hA9};
    tbl[2]  = '{1, 1, 0, 0, 0, 8'h00, VID,  0, 1, 8'hC3};
    tbl[3]  = '{1, 1, 0, 0, 0, 8'h00, DMA,  0, 1, 8'h7E};
    tbl[4]  = '{0, 1, 0, 0, 0, 8'h00, CPU,  0, 1, 8'hA9};
    tbl[5]  = '{0, 1, 0, 1, 0, 8'h00, DMA,  0, 1, 8'h7E};
    tbl[6]  = '{0, 0, 0, 0, 0, 8'h00, CPU,  0, 1, 8'hA9};
    tbl[7]  = '{0, 1, 0, 0, 0, 8'h00, DMA,  0, 1, 8'h7E};
    tbl[8]  = '{1, 0, 0, 1, 0, 8'h00, VID,  0, 1, 8'hC3};
    tbl[9]  = '{1, 0, 0, 1, 0, 8'h00, VID,  0, 1, 8'hC3};
    tbl[10] = '{0, 0, 0, 1, 0, 8'h00, NONE, 0, 0, 8'h00};
    tbl[11] = '{0, 1, 1, 1, 0, 8'h5A, DMA,  1, 0, 8'h00};
    tbl[12] = '{0, 0, 0, 0, 1, 8'h55, CPU,  1, 0, 8'h00};
    tbl[13] = '{0, 1, 0, 1, 0, 8'h00, DMA,  0, 1, 8'h5A};
    tbl[14] = '{0, 0, 0, 0, 0, 8'h00, CPU,  0, 1, 8'h55};
    tbl[15] = '{1, 0, 0, 0, 0, 8'h00, VID,  0, 1, 8'hC3};
    tbl[16] = '{1, 0, 0, 0, 0, 8'h00, CPU,  0, 1, 8'h55};
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    mem[16'h0010] = 8'hA9; mem[16'h2000] = 8'hC3; mem[16'h1234] = 8'h7E;
    ref_mem[16'h0010] = 8'hA9; ref_mem[16'h2000] = 8'hC3; ref_mem[16'h1234] = 8'h7E;
    cpu_address = 16'h0010; vid_address = 16'h2000; dma_address = 16'h1234;
    cpu_out = 8'h00; dma_wdata = 8'h00;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      vid_req = tbl[i].v; dma_req = tbl[i].d; dma_we = tbl[i].dwe; cpu_halt = tbl[i].halt;
      cpu_we = tbl[i].cwe; cpu_out = tbl[i].wd; dma_wdata = tbl[i].wd;
      slot(tbl[i].own, tbl[i].we, tbl[i].cd, tbl[i].dat, $sformatf("vec%0d", i));
      if (tbl[i].we) ref_mem[owner_addr(tbl[i].own)] = tbl[i].wd;
    end
    // reset pulsed in the DATA cycle of a DMA write slot
    vid_req = 0; cpu_halt = 1; cpu_we = 0;
    dma_req = 1; dma_we = 1; dma_address = 16'h0300; dma_wdata = 8'h99;
    @(negedge clock);
    chk("midreset addr we", mem_we, 1);
    chk("midreset addr", mem_address, 16'h0300);
    @(posedge clock);
    #1 reset_n = 0;
    @(negedge clock);
    chk("midreset no ack", {dma_ack, mem_we}, 0);
    chk("midreset write done", mem[16'h0300], 8'h99);
    ref_mem[16'h0300] = 8'h99;
    @(posedge clock);
    #1 reset_n = 1;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clock);
      got = dma_ack;
    end
    chk("midreset regrant", got, 1);
    dma_req = 0;
    do_reset();
    // randomized slots against the model
    vfree = 1; dfree = 1; cmoved = 1;
    vid_req = 0; dma_req = 0;
    for (int s = 0; s < 300; s++) begin
      if (vfree) begin vid_req = 1'($urandom_range(0, 1)); vid_address = 16'($urandom); end
      if (dfree) begin
        dma_req = 1'($urandom_range(0, 1)); dma_address = 16'($urandom);
        dma_we = 1'($urandom_range(0, 1)); dma_wdata = 8'($urandom);
      end
      if (cmoved) begin
        cpu_address = 16'($urandom); cpu_we = ($urandom_range(0, 3) == 0); cpu_out = 8'($urandom);
      end
      cpu_halt = ($urandom_range(0, 3) == 0);
      own = model_grant(vid_req, dma_req, !cpu_halt);
      a = owner_addr(own);
      got = (own == CPU && cpu_we) || (own == DMA && dma_we);
      slot(own, got, own != NONE && !got, ref_mem[a], $sformatf("rnd%0d", s));
      if (got) ref_mem[a] = own == DMA ? dma_wdata : cpu_out;
      vfree = own == VID || !vid_req;
      dfree = own == DMA || !dma_req;
      cmoved = own == CPU;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
